// File: rtl/navre_io_uart_pkg.sv
// Shared definitions for the navre IO-mapped UART transmitter.
// NAVRE_UART_PARITY_EN adds the PARITY state to the TX state encoding.
package navre_io_uart_pkg;

   localparam logic [5:0] DATA_ADDR_DEF = 6'd42;
   localparam logic [5:0] STAT_ADDR_DEF = 6'd43;

   localparam int unsigned ST_FULL  = 0;
   localparam int unsigned ST_EMPTY = 1;
   localparam int unsigned ST_BUSY  = 2;
   localparam int unsigned ST_OVF   = 3;
   localparam int unsigned ST_EOF   = 4;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
`ifdef NAVRE_UART_PARITY_EN
      StParity = 3'd3,
`endif
      StStop   = 3'd4
   } tx_state_e;

endpackage

// File: rtl/navre_io_uart_if.sv
// navre core IO bus: strobes, address and data in both directions.
interface navre_io_uart_if;

   logic       io_re;
   logic       io_we;
   logic [5:0] io_a;
   logic [7:0] io_do;
   logic [7:0] io_di;

   modport master (output io_re, io_we, io_a, io_do, input io_di);
   modport slave  (input io_re, io_we, io_a, io_do, output io_di);

endinterface

// File: rtl/navre_io_fifo.sv
// Synchronous byte FIFO, depth 2**FIFO_AW, with wrap-bit pointers.
module navre_io_fifo #(
   parameter int unsigned FIFO_AW = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty
);

   localparam int unsigned Depth = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] PtrOne = {{FIFO_AW{1'b0}}, 1'b1};

   logic [7:0]       mem [Depth];
   logic [FIFO_AW:0] wptr_q;
   logic [FIFO_AW:0] rptr_q;

   assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                  (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
   assign empty = (wptr_q == rptr_q);
   assign rdata = mem[rptr_q[FIFO_AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push && !full)  wptr_q <= wptr_q + PtrOne;
         if (pop  && !empty) rptr_q <= rptr_q + PtrOne;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) mem[wptr_q[FIFO_AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/navre_io_uart.sv
// IO-mapped 8N1 serial transmitter with TX FIFO, EOF marker and status port.
// Define NAVRE_UART_PARITY_EN to insert an even-parity bit before the stop bit.
module navre_io_uart
   import navre_io_uart_pkg::*;
#(
   parameter logic [5:0]  DATA_ADDR = DATA_ADDR_DEF,
   parameter logic [5:0]  STAT_ADDR = STAT_ADDR_DEF,
   parameter int unsigned CLK_DIV   = 16,
   parameter int unsigned FIFO_AW   = 4
) (
   input  logic             clk,
   input  logic             rst,
   navre_io_uart_if.slave   io,
   output logic             txd,
   output logic             eof,
   output logic             tx_busy
);

   localparam logic [15:0] BaudLast = 16'(CLK_DIV - 1);

   tx_state_e   state_q, state_d;
   logic [15:0] cnt_q;
   logic [2:0]  bit_q;
   logic [7:0]  shift_q;
`ifdef NAVRE_UART_PARITY_EN
   logic        par_q;
`endif

   logic       wr_data, wr_marker, wr_char, push, pop, full, empty, stat_rd, bit_done;
   logic [7:0] fifo_rdata, status, di_q;
   logic       ovf_q, eof_seen_q, eof_q;

   assign wr_data   = io.io_we && (io.io_a == DATA_ADDR);
   assign wr_marker = wr_data && (io.io_do == 8'h00);
   assign wr_char   = wr_data && (io.io_do != 8'h00);
   assign push      = wr_char && !full;
   assign stat_rd   = io.io_re && (io.io_a == STAT_ADDR);
   assign bit_done  = (cnt_q == BaudLast);

   navre_io_fifo #(
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (io.io_do),
      .rdata (fifo_rdata),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      status           = '0;
      status[ST_FULL]  = full;
      status[ST_EMPTY] = empty;
      status[ST_BUSY]  = (state_q != StIdle);
      status[ST_OVF]   = ovf_q;
      status[ST_EOF]   = eof_seen_q;
   end

   // Status is sampled before the read's overflow clear takes effect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         di_q       <= 8'h00;
         ovf_q      <= 1'b0;
         eof_seen_q <= 1'b0;
         eof_q      <= 1'b0;
      end else begin
         di_q  <= stat_rd ? status : 8'h00;
         eof_q <= wr_marker;
         if (wr_marker) eof_seen_q <= 1'b1;
         if (wr_char && full) ovf_q <= 1'b1;
         else if (stat_rd)    ovf_q <= 1'b0;
      end
   end

   assign io.io_di = di_q;
   assign eof      = eof_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= StIdle;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (!empty) state_d = StStart;
         StStart: if (bit_done) state_d = StData;
`ifdef NAVRE_UART_PARITY_EN
         StData:   if (bit_done && (bit_q == 3'd7)) state_d = StParity;
         StParity: if (bit_done) state_d = StStop;
`else
         StData:  if (bit_done && (bit_q == 3'd7)) state_d = StStop;
`endif
         StStop:  if (bit_done) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      pop     = (state_q == StIdle) && !empty;
      tx_busy = !empty || (state_q != StIdle);
      txd     = 1'b1;
      unique case (state_q)
         StStart:  txd = 1'b0;
         StData:   txd = shift_q[0];
`ifdef NAVRE_UART_PARITY_EN
         StParity: txd = par_q;
`endif
         default:  txd = 1'b1;
      endcase
   end

   // Baud counter restarts on every state change and on every data bit boundary.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= 16'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
`ifdef NAVRE_UART_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         if ((state_d != state_q) || bit_done) cnt_q <= 16'd0;
         else                                  cnt_q <= cnt_q + 16'd1;
         if (pop) begin
            shift_q <= fifo_rdata;
            bit_q   <= 3'd0;
`ifdef NAVRE_UART_PARITY_EN
            par_q   <= ^fifo_rdata;
`endif
         end else if ((state_q == StData) && bit_done) begin
            shift_q <= shift_q >> 1;
            bit_q   <= bit_q + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_navre_io_uart.sv
// Bench for navre_io_uart: register-path vector table, exact frame waveforms,
// and randomized traffic decoded by a behavioural UART receiver.
module tb_navre_io_uart;

   localparam int unsigned CLK_DIV = 4;
`ifdef NAVRE_UART_PARITY_EN
   localparam int unsigned NBITS = 11;
`else
   localparam int unsigned NBITS = 10;
`endif
   localparam int unsigned FRAME = NBITS * CLK_DIV;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic txd, eof, tx_busy;

   navre_io_uart_if bus ();

   navre_io_uart #(
      .DATA_ADDR (6'd42),
      .STAT_ADDR (6'd43),
      .CLK_DIV   (CLK_DIV),
      .FIFO_AW   (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .io      (bus),
      .txd     (txd),
      .eof     (eof),
      .tx_busy (tx_busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural receiver: detect start, sample mid-bit, check parity/stop.
   logic [7:0] rx_q[$];
   int         rx_start_q[$];
   bit         rx_en = 1'b0;

   initial begin
      logic [7:0] b;
      int         st;
      forever begin
         @(negedge clk);
         if (rx_en && rst && (txd === 1'b0)) begin
            st = cyc;
            repeat (CLK_DIV + CLK_DIV / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               b[i] = txd;
               if (i < 7) repeat (CLK_DIV) @(negedge clk);
            end
`ifdef NAVRE_UART_PARITY_EN
            repeat (CLK_DIV) @(negedge clk);
            check("rx_parity", {31'd0, txd}, {31'd0, ^b});
`endif
            repeat (CLK_DIV) @(negedge clk);
            check("rx_stop", {31'd0, txd}, 32'd1);
            rx_q.push_back(b);
            rx_start_q.push_back(st);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic       re;
      logic       we;
      logic [5:0] a;
      logic [7:0] d;
      logic [7:0] exp_di;
      logic       exp_eof;
   } vec_t;

   vec_t tbl[9];

   task automatic bus_idle();
      bus.io_re = 1'b0;
      bus.io_we = 1'b0;
      bus.io_a  = 6'd0;
      bus.io_do = 8'h00;
   endtask

   task automatic rd_status(input string name, input logic [7:0] exp);
      @(negedge clk);
      bus.io_re = 1'b1;
      bus.io_a  = 6'd43;
      @(negedge clk);
      bus.io_re = 1'b0;
      check(name, {24'd0, bus.io_di}, {24'd0, exp});
   endtask

   task automatic wait_rx(input int n, input int budget);
      int t = 0;
      while ((rx_q.size() < n) && (t < budget)) begin
         @(negedge clk);
         t++;
      end
      check("rx_count", rx_q.size(), n);
   endtask

   task automatic wait_idle(input int budget);
      int t = 0;
      while ((tx_busy !== 1'b0) && (t < budget)) begin
         @(negedge clk);
         t++;
      end
      check("idle_timeout", {31'd0, tx_busy}, 32'd0);
   endtask

   // Cycle-exact frame: txd falls one edge after the push edge.
   task automatic frame_exact(input logic [7:0] d);
      logic [NBITS-1:0] bits;
`ifdef NAVRE_UART_PARITY_EN
      bits = {1'b1, ^d, d, 1'b0};
`else
      bits = {1'b1, d, 1'b0};
`endif
      @(negedge clk);
      bus.io_we = 1'b1;
      bus.io_a  = 6'd42;
      bus.io_do = d;
      @(negedge clk);
      bus.io_we = 1'b0;
      check("frame_pre_txd", {31'd0, txd}, 32'd1);
      check("frame_pre_busy", {31'd0, tx_busy}, 32'd1);
      for (int k = 0; k < int'(FRAME); k++) begin
         @(negedge clk);
         check("frame_txd", {31'd0, txd}, {31'd0, bits[k / CLK_DIV]});
         check("frame_busy", {31'd0, tx_busy}, 32'd1);
      end
      @(negedge clk);
      check("frame_end_txd", {31'd0, txd}, 32'd1);
      check("frame_end_busy", {31'd0, tx_busy}, 32'd0);
   endtask

   initial begin
      logic [7:0] exp_q[$];
      logic [7:0] d;
      int         n, r, nexp;
      bit         eof_m;

      tbl[0] = '{re: 1, we: 0, a: 43, d: 8'h00, exp_di: 8'h02, exp_eof: 0};
      tbl[1] = '{re: 1, we: 0, a: 10, d: 8'h00, exp_di: 8'h00, exp_eof: 0};
      tbl[2] = '{re: 0, we: 1, a: 41, d: 8'h55, exp_di: 8'h00, exp_eof: 0};
      tbl[3] = '{re: 1, we: 0, a: 43, d: 8'h00, exp_di: 8'h02, exp_eof: 0};
      tbl[4] = '{re: 0, we: 1, a: 42, d: 8'h00, exp_di: 8'h00, exp_eof: 1};
      tbl[5] = '{re: 1, we: 0, a: 43, d: 8'h00, exp_di: 8'h12, exp_eof: 0};
      tbl[6] = '{re: 1, we: 1, a: 43, d: 8'h00, exp_di: 8'h12, exp_eof: 0};
      tbl[7] = '{re: 0, we: 1, a: 41, d: 8'h00, exp_di: 8'h00, exp_eof: 0};
      tbl[8] = '{re: 1, we: 0, a: 42, d: 8'h00, exp_di: 8'h00, exp_eof: 0};

      bus_idle();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_io_di", {24'd0, bus.io_di}, 32'd0);
      check("rst_txd", {31'd0, txd}, 32'd1);
      check("rst_eof", {31'd0, eof}, 32'd0);
      check("rst_busy", {31'd0, tx_busy}, 32'd0);
      rst   = 1'b1;
      rx_en = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clk);
         bus.io_re = tbl[i].re;
         bus.io_we = tbl[i].we;
         bus.io_a  = tbl[i].a;
         bus.io_do = tbl[i].d;
         @(negedge clk);
         bus_idle();
         check("tbl_di", {24'd0, bus.io_di}, {24'd0, tbl[i].exp_di});
         check("tbl_eof", {31'd0, eof}, {31'd0, tbl[i].exp_eof});
         check("tbl_busy", {31'd0, tx_busy}, 32'd0);
      end

      // EOF marker: single-cycle pulse, nothing queued.
      @(negedge clk);
      bus.io_we = 1'b1;
      bus.io_a  = 6'd42;
      bus.io_do = 8'h00;
      @(negedge clk);
      bus_idle();
      check("eof_pulse", {31'd0, eof}, 32'd1);
      @(negedge clk);
      check("eof_pulse_end", {31'd0, eof}, 32'd0);
      repeat (4) @(negedge clk);
      check("eof_no_tx", {31'd0, txd}, 32'd1);
      check("eof_no_busy", {31'd0, tx_busy}, 32'd0);

      frame_exact(8'h41);
      nexp = 1;
`ifdef NAVRE_UART_PARITY_EN
      frame_exact(8'h07);
      frame_exact(8'h03);
      nexp = 3;
`endif
      wait_rx(nexp, 100);
      check("rx_41", {24'd0, rx_q.pop_front()}, 32'h41);
`ifdef NAVRE_UART_PARITY_EN
      check("rx_07", {24'd0, rx_q.pop_front()}, 32'h07);
      check("rx_03", {24'd0, rx_q.pop_front()}, 32'h03);
`endif
      rx_q.delete();
      rx_start_q.delete();

      // Overflow: 20 back-to-back writes into a 16-deep FIFO.
      for (int v = 1; v <= 20; v++) begin
         @(negedge clk);
         bus.io_we = 1'b1;
         bus.io_a  = 6'd42;
         bus.io_do = 8'(v);
      end
      @(negedge clk);
      bus_idle();
      rd_status("ovf_status", 8'h1D);
      rd_status("ovf_cleared", 8'h15);
      wait_rx(17, 17 * (FRAME + 1) + 200);
      for (int v = 1; v <= 17; v++) begin
         if (rx_q.size() > 0) check("ovf_byte", {24'd0, rx_q.pop_front()}, v);
      end
      for (int i = 1; i < rx_start_q.size(); i++) begin
         check("ovf_gap", rx_start_q[i] - rx_start_q[i-1], FRAME + 1);
      end
      rx_q.delete();
      rx_start_q.delete();
      wait_idle(200);
      rd_status("post_ovf_status", 8'h12);

      // Reset during START aborts the frame asynchronously.
      rx_en = 1'b0;
      @(negedge clk);
      bus.io_we = 1'b1;
      bus.io_a  = 6'd42;
      bus.io_do = 8'h55;
      @(negedge clk);
      bus_idle();
      @(negedge clk);
      check("mid_frame_txd", {31'd0, txd}, 32'd0);
      #2 rst = 1'b0;
      #1;
      check("async_rst_txd", {31'd0, txd}, 32'd1);
      check("async_rst_busy", {31'd0, tx_busy}, 32'd0);
      check("async_rst_di", {24'd0, bus.io_di}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      rd_status("post_rst_status", 8'h02);
      rx_q.delete();
      rx_start_q.delete();
      rx_en = 1'b1;

      // Randomized traffic against the expected-byte queue.
      eof_m = 1'b0;
      for (int batch = 0; batch < 4; batch++) begin
         n = $urandom_range(16, 4);
         exp_q.delete();
         while (exp_q.size() < n) begin
            r = $urandom_range(9, 0);
            @(negedge clk);
            bus.io_we = 1'b1;
            if (r == 0) begin
               bus.io_a  = 6'd42;
               bus.io_do = 8'h00;
               eof_m     = 1'b1;
            end else if (r == 1) begin
               bus.io_a  = 6'($urandom_range(41, 0));
               bus.io_do = 8'($urandom_range(255, 0));
            end else begin
               d         = 8'($urandom_range(255, 1));
               bus.io_a  = 6'd42;
               bus.io_do = d;
               exp_q.push_back(d);
            end
            @(negedge clk);
            bus_idle();
            repeat ($urandom_range(1, 0)) @(negedge clk);
         end
         wait_rx(n, n * (FRAME + 1) + 200);
         while ((exp_q.size() > 0) && (rx_q.size() > 0)) begin
            check("rand_byte", {24'd0, rx_q.pop_front()}, {24'd0, exp_q.pop_front()});
         end
         rx_q.delete();
         rx_start_q.delete();
         wait_idle(200);
         rd_status("rand_status", eof_m ? 8'h12 : 8'h02);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
